// File: rtl/ss_read_data.sv
// ss_read_data: streams RAM words from a start index to an end index (both inclusive)
// onto a valid/ready interface.
//
// Ports:
//   i_clk             clock; all state changes on the rising edge
//   i_rst             synchronous active-high reset
//   i_start_read_data start pulse, honoured only while idle
//   i_si_ram          start index, sampled with start
//   i_ei_ram          end index, sampled with start
//   o_re_ram          RAM read strobe
//   o_addr_ram        RAM read address, valid while o_re_ram=1
//   i_data_ram        RAM read data, valid the cycle after o_re_ram=1
//   o_data            stream data (FIFO head)
//   o_valid           o_data holds a word
//   i_ready           consumer accepts; transfer when o_valid && i_ready
//   o_busy            high in every state except idle
//   o_done_read_data  one-cycle completion pulse
module ss_read_data #(
    parameter int unsigned SIZE_ADDR = 6,
    parameter int unsigned SIZE_DATA = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start_read_data,
    input  logic [SIZE_ADDR-1:0] i_si_ram,
    input  logic [SIZE_ADDR-1:0] i_ei_ram,
    output logic                 o_re_ram,
    output logic [SIZE_ADDR-1:0] o_addr_ram,
    input  logic [SIZE_DATA-1:0] i_data_ram,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_done_read_data
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e state_q, state_d;

    // One extra bit so an end index of all-ones terminates without wrapping.
    logic [SIZE_ADDR:0]   ptr_q;
    logic [SIZE_ADDR:0]   ei_q;
    logic                 inflight_q;
    logic [SIZE_DATA-1:0] fifo_q [2];
    logic                 rd_idx_q;
    logic [1:0]           count_q;

    logic                 pop;
    logic                 push;
    logic                 issue;
    logic                 wr_idx;
    logic [2:0]           occ;
    logic [2:0]           limit;

    assign pop    = (count_q != 2'd0) && i_ready;
    assign push   = inflight_q;
    assign wr_idx = rd_idx_q ^ count_q[0];

    // Issue only if the word can be buffered: buffered + in-flight - popped < 2.
    assign occ    = {1'b0, count_q} + {2'b00, inflight_q};
    assign limit  = 3'd2 + {2'b00, pop};
    assign issue  = (state_q == StRead) && (occ < limit);

    // State register and datapath.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            ei_q       <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_idx_q   <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && i_start_read_data) begin
                ptr_q <= {1'b0, i_si_ram};
                ei_q  <= {1'b0, i_ei_ram};
            end else if (issue) begin
                ptr_q <= ptr_q + 1'b1;
            end
            inflight_q <= issue;
            if (push) begin
                fifo_q[wr_idx] <= i_data_ram;
            end
            count_q  <= count_q + {1'b0, push} - {1'b0, pop};
            rd_idx_q <= rd_idx_q ^ pop;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_start_read_data) begin
                    state_d = (i_si_ram <= i_ei_ram) ? StRead : StDone;
                end
            end
            StRead: begin
                if (issue && (ptr_q == ei_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; forced to zero while reset is asserted.
    always_comb begin
        o_re_ram         = issue && !i_rst;
        o_addr_ram       = o_re_ram ? ptr_q[SIZE_ADDR-1:0] : '0;
        o_valid          = (count_q != 2'd0) && !i_rst;
        o_data           = o_valid ? fifo_q[rd_idx_q] : '0;
        o_busy           = (state_q != StIdle) && !i_rst;
        o_done_read_data = (state_q == StDone) && !i_rst;
    end

endmodule

// File: tb/tb_ss_read_data.sv
module tb_ss_read_data;

    logic       clk;
    logic       i_rst;
    logic       i_start;
    logic [5:0] i_si;
    logic [5:0] i_ei;
    logic       o_re_ram;
    logic [5:0] o_addr_ram;
    logic [7:0] i_data_ram;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_busy;
    logic       o_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram [64];

    // Observations gathered by run_op; each test compares them against its own model.
    int rd_addr_q[$];
    int rd_cyc_q[$];
    int dat_q[$];
    int dat_cyc_q[$];
    int done_cyc_q[$];
    int stall_viol;
    int max_out;
    int extra_ev;
    int rst_zero_bad;
    int timed_out;

    ss_read_data #(.SIZE_ADDR(6), .SIZE_DATA(8)) dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_start_read_data (i_start),
        .i_si_ram          (i_si),
        .i_ei_ram          (i_ei),
        .o_re_ram          (o_re_ram),
        .o_addr_ram        (o_addr_ram),
        .i_data_ram        (i_data_ram),
        .o_data            (o_data),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_busy            (o_busy),
        .o_done_read_data  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: data for a strobed address appears in the following cycle;
    // garbage otherwise so stray captures show up.
    always @(posedge clk) begin
        if (o_re_ram) i_data_ram <= ram[o_addr_ram];
        else          i_data_ram <= 8'($urandom);
    end

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 1;
        return $urandom_range(0, 1) == 1;
    endfunction

    // Starts one operation and records what the DUT does, cycle by cycle.
    // Cycle 1 is the first cycle after the edge that samples start.
    task automatic run_op(input int si, input int ei, input int mode, input int start2,
                          input int rst_words);
        int   cyc;
        int   issued;
        int   tail;
        bit   rst_hit;
        bit   complete;
        logic pv;
        logic pr;
        logic [7:0] pd;
        rd_addr_q.delete(); rd_cyc_q.delete(); dat_q.delete(); dat_cyc_q.delete();
        done_cyc_q.delete();
        stall_viol = 0; max_out = 0; extra_ev = 0; rst_zero_bad = 0; timed_out = 0;
        cyc = 0; issued = 0; tail = 0; rst_hit = 0; complete = 0; pv = 0; pr = 0; pd = 0;
        @(negedge clk);
        i_start = 1'b1; i_si = 6'(si); i_ei = 6'(ei); i_ready = 1'b1;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            i_start = (cyc == start2);
            if (cyc == start2) begin
                i_si = 6'd20; i_ei = 6'd25;
            end
            i_ready = pick_ready(mode, cyc);
            i_rst = (rst_words > 0) && (dat_q.size() >= rst_words) && !rst_hit;
            #1;
            if (tail > 0) begin
                if (o_re_ram || o_valid || o_done || o_busy) extra_ev++;
                tail--;
                if (tail == 0) begin
                    complete = 1;
                    break;
                end
            end else if (i_rst) begin
                rst_hit = 1;
                if (o_re_ram || o_valid || o_busy || o_done || o_addr_ram != 0 || o_data != 0)
                    rst_zero_bad++;
                tail = 4;
            end else begin
                if (o_re_ram) begin
                    rd_addr_q.push_back(int'(o_addr_ram));
                    rd_cyc_q.push_back(cyc);
                    issued++;
                end
                if (pv && !pr && (!o_valid || o_data !== pd)) stall_viol++;
                if (o_valid && i_ready) begin
                    dat_q.push_back(int'(o_data));
                    dat_cyc_q.push_back(cyc);
                end
                if (issued - dat_q.size() > max_out) max_out = issued - dat_q.size();
                if (o_done) begin
                    done_cyc_q.push_back(cyc);
                    tail = 2;
                end
                pv = o_valid; pr = i_ready; pd = o_data;
            end
        end
        i_rst = 1'b0; i_start = 1'b0;
        if (!complete) timed_out = 1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b1; i_si = 6'd1; i_ei = 6'd4; i_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (o_re_ram !== 1'b0) begin errors++; $display("FAIL rst_re got=%b want=0", o_re_ram); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", o_done); end
        checks++; if (o_addr_ram !== 6'd0) begin errors++; $display("FAIL rst_addr got=%h want=0", o_addr_ram); end
        checks++; if (o_data !== 8'd0) begin errors++; $display("FAIL rst_data got=%h want=0", o_data); end
        @(negedge clk);
        i_rst = 1'b0; i_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal();
        for (int a = 0; a < 64; a++) ram[a] = 8'(a);
        run_op(5, 10, 0, 0, 0);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL normal_timeout got=%0d want=0", timed_out); end
        checks++; if (dat_q.size() != 6) begin errors++; $display("FAIL normal_words got=%0d want=6", dat_q.size()); end
        checks++; if (rd_addr_q.size() != 6) begin errors++; $display("FAIL normal_reads got=%0d want=6", rd_addr_q.size()); end
        for (int i = 0; i < dat_q.size(); i++) begin
            checks++; if (dat_q[i] != 5 + i) begin errors++; $display("FAIL normal_data[%0d] got=%h want=%h", i, dat_q[i], 5 + i); end
            checks++; if (dat_cyc_q[i] != 3 + i) begin errors++; $display("FAIL normal_dcyc[%0d] got=%0d want=%0d", i, dat_cyc_q[i], 3 + i); end
        end
        for (int i = 0; i < rd_addr_q.size(); i++) begin
            checks++; if (rd_addr_q[i] != 5 + i) begin errors++; $display("FAIL normal_addr[%0d] got=%0d want=%0d", i, rd_addr_q[i], 5 + i); end
            checks++; if (rd_cyc_q[i] != 1 + i) begin errors++; $display("FAIL normal_rcyc[%0d] got=%0d want=%0d", i, rd_cyc_q[i], 1 + i); end
        end
        checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL normal_done_cnt got=%0d want=1", done_cyc_q.size()); end
        else begin
            checks++; if (done_cyc_q[0] != 9) begin errors++; $display("FAIL normal_done_cyc got=%0d want=9", done_cyc_q[0]); end
        end
        checks++; if (extra_ev != 0) begin errors++; $display("FAIL normal_after_done got=%0d want=0", extra_ev); end
    endtask

    task automatic test_backpressure();
        for (int a = 0; a < 64; a++) ram[a] = {2'b11, 6'(a)};
        run_op(0, 3, 1, 0, 0);
        checks++; if (dat_q.size() != 4) begin errors++; $display("FAIL bp_words got=%0d want=4", dat_q.size()); end
        for (int i = 0; i < dat_q.size(); i++) begin
            checks++; if (dat_q[i] != 'hC0 + i) begin errors++; $display("FAIL bp_data[%0d] got=%h want=%h", i, dat_q[i], 'hC0 + i); end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got=%0d want=0", stall_viol); end
        checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding got=%0d want<=2", max_out); end
        checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL bp_done_cnt got=%0d want=1", done_cyc_q.size()); end
        checks++; if (timed_out != 0) begin errors++; $display("FAIL bp_timeout got=%0d want=0", timed_out); end
    endtask

    task automatic test_top_single();
        ram[63] = 8'hBB;
        run_op(63, 63, 0, 0, 0);
        checks++; if (rd_addr_q.size() != 1) begin errors++; $display("FAIL top_reads got=%0d want=1", rd_addr_q.size()); end
        else begin
            checks++; if (rd_addr_q[0] != 63) begin errors++; $display("FAIL top_addr got=%0d want=63", rd_addr_q[0]); end
        end
        checks++; if (dat_q.size() != 1) begin errors++; $display("FAIL top_words got=%0d want=1", dat_q.size()); end
        else begin
            checks++; if (dat_q[0] != 'hBB) begin errors++; $display("FAIL top_data got=%h want=bb", dat_q[0]); end
        end
        checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL top_done_cnt got=%0d want=1", done_cyc_q.size()); end
        checks++; if (extra_ev != 0 || timed_out != 0) begin errors++; $display("FAIL top_after got=%0d/%0d want=0/0", extra_ev, timed_out); end
    endtask

    task automatic test_empty();
        run_op(12, 8, 0, 0, 0);
        checks++; if (rd_addr_q.size() != 0) begin errors++; $display("FAIL empty_reads got=%0d want=0", rd_addr_q.size()); end
        checks++; if (dat_q.size() != 0) begin errors++; $display("FAIL empty_words got=%0d want=0", dat_q.size()); end
        checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL empty_done_cnt got=%0d want=1", done_cyc_q.size()); end
        else begin
            checks++; if (done_cyc_q[0] != 1) begin errors++; $display("FAIL empty_done_cyc got=%0d want=1", done_cyc_q[0]); end
        end
    endtask

    task automatic test_busy_start();
        for (int a = 0; a < 64; a++) ram[a] = 8'(a ^ 'h5A);
        run_op(8, 12, 0, 3, 0);
        checks++; if (dat_q.size() != 5) begin errors++; $display("FAIL busy_words got=%0d want=5", dat_q.size()); end
        for (int i = 0; i < dat_q.size(); i++) begin
            checks++; if (dat_q[i] != int'(ram[8 + i])) begin errors++; $display("FAIL busy_data[%0d] got=%h want=%h", i, dat_q[i], ram[8 + i]); end
        end
        checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL busy_done_cnt got=%0d want=1", done_cyc_q.size()); end
        checks++; if (extra_ev != 0) begin errors++; $display("FAIL busy_after got=%0d want=0", extra_ev); end
    endtask

    task automatic test_reset_mid();
        for (int a = 0; a < 64; a++) ram[a] = 8'(a);
        run_op(8, 12, 0, 0, 2);
        checks++; if (rst_zero_bad != 0) begin errors++; $display("FAIL rmid_zero got=%0d want=0", rst_zero_bad); end
        checks++; if (dat_q.size() != 2) begin errors++; $display("FAIL rmid_words got=%0d want=2", dat_q.size()); end
        checks++; if (done_cyc_q.size() != 0) begin errors++; $display("FAIL rmid_done got=%0d want=0", done_cyc_q.size()); end
        checks++; if (extra_ev != 0) begin errors++; $display("FAIL rmid_after got=%0d want=0", extra_ev); end
        run_op(0, 1, 0, 0, 0);
        checks++; if (dat_q.size() != 2) begin errors++; $display("FAIL rmid_fresh_words got=%0d want=2", dat_q.size()); end
        for (int i = 0; i < dat_q.size(); i++) begin
            checks++; if (dat_q[i] != i) begin errors++; $display("FAIL rmid_fresh_data[%0d] got=%h want=%h", i, dat_q[i], i); end
        end
        checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL rmid_fresh_done got=%0d want=1", done_cyc_q.size()); end
    endtask

    task automatic test_random();
        int si;
        int ei;
        int exp_q[$];
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 64; a++) ram[a] = 8'($urandom);
            si = $urandom_range(0, 63);
            if ($urandom_range(0, 4) == 0) ei = $urandom_range(0, 63);
            else ei = (si + $urandom_range(0, 12) > 63) ? 63 : si + $urandom_range(0, 12);
            exp_q.delete();
            for (int a = si; a <= ei; a++) exp_q.push_back(int'(ram[a]));
            run_op(si, ei, 2, 0, 0);
            checks++; if (dat_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_words got=%0d want=%0d", it, dat_q.size(), exp_q.size()); end
            for (int i = 0; i < dat_q.size() && i < exp_q.size(); i++) begin
                checks++; if (dat_q[i] != exp_q[i]) begin errors++; $display("FAIL rand%0d_data[%0d] got=%h want=%h", it, i, dat_q[i], exp_q[i]); end
            end
            checks++; if (stall_viol != 0 || max_out > 2) begin errors++; $display("FAIL rand%0d_flow got=%0d/%0d want=0/<=2", it, stall_viol, max_out); end
            checks++; if (done_cyc_q.size() != 1 || timed_out != 0) begin errors++; $display("FAIL rand%0d_done got=%0d/%0d want=1/0", it, done_cyc_q.size(), timed_out); end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_si = '0; i_ei = '0; i_ready = 1'b0;
        for (int a = 0; a < 64; a++) ram[a] = '0;
        test_reset();
        test_normal();
        test_backpressure();
        test_top_single();
        test_empty();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ss_read_data.md
SS_READ_DATA -- requirements
Module: SS_read_data

Interface
REQ-001 SHALL have parameter SIZE_ADDR, default 6, RAM address width.
REQ-002 SHALL have parameter SIZE_DATA, default 8, RAM data width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port i_clk, input, 1 bit, clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port i_start_read_data, input, 1 bit, start pulse; honoured only in IDLE.
REQ-007 SHALL have port i_si_ram, input, SIZE_ADDR bits, start index (inclusive); sampled with start.
REQ-008 SHALL have port i_ei_ram, input, SIZE_ADDR bits, end index (inclusive); sampled with start.
REQ-009 SHALL have port o_re_ram, output, 1 bit, RAM read strobe.
REQ-010 SHALL have port o_addr_ram, output, SIZE_ADDR bits, RAM read address; valid while o_re_ram=1.
REQ-011 SHALL have port i_data_ram, input, SIZE_DATA bits, RAM read data; valid the cycle after o_re_ram=1.
REQ-012 SHALL have port o_data, output, SIZE_DATA bits, stream data.
REQ-013 SHALL have port o_valid, output, 1 bit, o_data holds a word.
REQ-014 SHALL have port i_ready, input, 1 bit, consumer accepts; a transfer occurs when o_valid=1 and i_ready=1.
REQ-015 SHALL have port o_busy, output, 1 bit, high in every state except IDLE.
REQ-016 SHALL have port o_done_read_data, output, 1 bit, one-cycle completion pulse.

Function
REQ-017 SHALL implement the states IDLE, READ, DRAIN and DONE.
REQ-018 IDLE -> READ SHALL occur on i_start_read_data=1 with i_si_ram<=i_ei_ram, latching si/ei; the read pointer SHALL load si.
REQ-019 IDLE -> DONE SHALL occur on start with i_si_ram>i_ei_ram: empty range, no o_re_ram, no o_valid.
REQ-020 In READ, o_re_ram SHALL be 1 with o_addr_ram=pointer when (buffered + in-flight - pop_this_cycle) < 2; the pointer SHALL increment per issued read.
REQ-021 The pointer/compare logic SHALL be SIZE_ADDR+1 bits wide so that ei=2^SIZE_ADDR-1 terminates without wrap-around; issued addresses SHALL never exceed ei.
REQ-022 READ -> DRAIN SHALL occur in the cycle after the read of address ei is issued.
REQ-023 Return data SHALL be captured into a 2-entry FIFO at the end of the cycle following the matching o_re_ram.
REQ-024 o_valid SHALL equal FIFO non-empty; o_data SHALL equal the FIFO head; output order SHALL equal address order.
REQ-025 o_data and o_valid SHALL hold stable while o_valid=1 and i_ready=0; no word SHALL be lost or duplicated.
REQ-026 DRAIN -> DONE SHALL occur on the cycle the last word transfers with no read in flight.
REQ-027 In DONE, o_done_read_data SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-028 Latency: with start sampled at edge T, the first o_re_ram SHALL be in cycle T+1 and the first o_valid in cycle T+3.
REQ-029 Throughput: with i_ready held at 1, one word SHALL transfer per cycle, back to back.
REQ-030 i_start_read_data while o_busy=1 SHALL be ignored, with no change to the latched si/ei.
REQ-031 A range si=ei SHALL produce exactly one read and one word.

Reset
REQ-032 i_rst=1 SHALL force state IDLE and clear the FIFO, pointer and in-flight flag.
REQ-033 During i_rst=1, o_re_ram, o_valid, o_busy and o_done_read_data SHALL all be 0, and o_addr_ram and o_data SHALL be 0.
REQ-034 Reset mid-operation SHALL abort immediately; the RAM data of a read issued before reset SHALL be discarded, with no done pulse.

Verification
REQ-035 Normal range: RAM[a]=a, si=5, ei=10, i_ready=1 -> o_data 0x05..0x0A in six consecutive cycles starting at T+3, reads at T+1..T+6, done one cycle after the 0x0A transfer.
REQ-036 Backpressure: si=0, ei=3, RAM[a]={2'b11,a}, i_ready toggling 1,0,0,1,... -> 0xC0..0xC3 in order, data stable while stalled, at most 2 reads outstanding plus buffered.
REQ-037 Single word at top address: si=ei=63, RAM[63]=0xBB -> exactly one read at address 63, one word 0xBB, done pulse, no pointer wrap.
REQ-038 Empty range: si=12, ei=8 -> no o_re_ram, no o_valid, o_done_read_data pulses in the cycle after start.
REQ-039 Start while busy: a second start with si=20 during si=8..12 -> ignored; only 8..12 are delivered.
REQ-040 Reset mid-transfer: i_rst=1 after 2 words of 8..12 -> all outputs 0 the next cycle, no done pulse; a fresh start of 0..1 then delivers exactly 2 words.
